// File: rtl/accelerator_write_interface_vector.sv
// Splits a write-interface vector streamed on XI_IN into its fields
// (k, beta, e, v, ga, gw) and strobes each one out on its own registered port.
module accelerator_write_interface_vector #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 XI_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] XI_IN,
  output logic [DATA_SIZE-1:0] K_OUT,
  output logic                 K_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] BETA_OUT,
  output logic                 BETA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] E_OUT,
  output logic                 E_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] V_OUT,
  output logic                 V_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] GA_OUT,
  output logic                 GA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] GW_OUT,
  output logic                 GW_OUT_ENABLE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    BETA   = 3'd2,
    ERASE  = 3'd3,
    VECTOR = 3'd4,
    GA     = 3'd5,
    GW     = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam logic [DATA_SIZE-1:0] ZERO_W = {DATA_SIZE{1'b0}};
  localparam logic [DATA_SIZE-1:0] ONE_W  = DATA_SIZE'(1'b1);
  // CONTROL_SIZE is carried only for family compatibility; this term is always 1
  localparam logic CONTROL_OK = (CONTROL_SIZE == CONTROL_SIZE);

  state_t                 state_r, state_s;
  logic [DATA_SIZE-1:0]   index_r, index_s;
  logic [DATA_SIZE-1:0]   size_w_r, size_w_s;
  logic                   accept_s;
  logic                   last_s;

  logic [DATA_SIZE-1:0]   k_r, beta_r, e_r, v_r, ga_r, gw_r;
  logic                   k_en_r, beta_en_r, e_en_r, v_en_r, ga_en_r, gw_en_r;
  logic                   ready_r;

  // Next-state, element index and latched word width
  always_comb begin
    state_s  = state_r;
    index_s  = index_r;
    size_w_s = size_w_r;
    accept_s = XI_IN_ENABLE & CONTROL_OK & (state_r != IDLE) & (state_r != DONE);
    last_s   = (size_w_r != ZERO_W) && (index_r == (size_w_r - ONE_W));
    case (state_r)
      IDLE: begin
        if (START) begin
          size_w_s = SIZE_W_IN;
          index_s  = ZERO_W;
          state_s  = (SIZE_W_IN == ZERO_W) ? BETA : KEY;
        end else begin
          state_s = IDLE;
        end
      end
      KEY, ERASE, VECTOR: begin
        if (accept_s) begin
          if (last_s) begin
            index_s = ZERO_W;
            case (state_r)
              KEY:     state_s = BETA;
              ERASE:   state_s = VECTOR;
              default: state_s = GA;
            endcase
          end else begin
            index_s = index_r + ONE_W;
          end
        end else begin
          index_s = index_r;
        end
      end
      BETA: begin
        if (accept_s) begin
          state_s = (size_w_r == ZERO_W) ? GA : ERASE;
        end else begin
          state_s = BETA;
        end
      end
      GA: begin
        if (accept_s) begin
          state_s = GW;
        end else begin
          state_s = GA;
        end
      end
      GW: begin
        if (accept_s) begin
          state_s = DONE;
        end else begin
          state_s = GW;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Parser state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= IDLE;
      index_r  <= ZERO_W;
      size_w_r <= ZERO_W;
    end else begin
      state_r  <= state_s;
      index_r  <= index_s;
      size_w_r <= size_w_s;
    end
  end

  // Field outputs: data holds between strobes, each strobe lasts one cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k_r       <= ZERO_W;
      beta_r    <= ZERO_W;
      e_r       <= ZERO_W;
      v_r       <= ZERO_W;
      ga_r      <= ZERO_W;
      gw_r      <= ZERO_W;
      k_en_r    <= 1'b0;
      beta_en_r <= 1'b0;
      e_en_r    <= 1'b0;
      v_en_r    <= 1'b0;
      ga_en_r   <= 1'b0;
      gw_en_r   <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      k_en_r    <= 1'b0;
      beta_en_r <= 1'b0;
      e_en_r    <= 1'b0;
      v_en_r    <= 1'b0;
      ga_en_r   <= 1'b0;
      gw_en_r   <= 1'b0;
      ready_r   <= (state_r == DONE);
      if (accept_s) begin
        case (state_r)
          KEY:    begin k_r    <= XI_IN; k_en_r    <= 1'b1; end
          BETA:   begin beta_r <= XI_IN; beta_en_r <= 1'b1; end
          ERASE:  begin e_r    <= XI_IN; e_en_r    <= 1'b1; end
          VECTOR: begin v_r    <= XI_IN; v_en_r    <= 1'b1; end
          GA:     begin ga_r   <= XI_IN; ga_en_r   <= 1'b1; end
          GW:     begin gw_r   <= XI_IN; gw_en_r   <= 1'b1; end
          default: begin end
        endcase
      end
    end
  end

  assign K_OUT           = k_r;
  assign K_OUT_ENABLE    = k_en_r;
  assign BETA_OUT        = beta_r;
  assign BETA_OUT_ENABLE = beta_en_r;
  assign E_OUT           = e_r;
  assign E_OUT_ENABLE    = e_en_r;
  assign V_OUT           = v_r;
  assign V_OUT_ENABLE    = v_en_r;
  assign GA_OUT          = ga_r;
  assign GA_OUT_ENABLE   = ga_en_r;
  assign GW_OUT          = gw_r;
  assign GW_OUT_ENABLE   = gw_en_r;
  assign READY           = ready_r;

endmodule
